// File: rtl/sys_ctrl_rx_cmd.sv
// rtl/sys_ctrl_rx_cmd.sv - UART command frame decoder driving the register file, ALU and TX FIFO.
// Every output is registered; strobes are asserted for exactly one cycle.
module sys_ctrl_rx_cmd #(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 4,
  parameter int ALU_OUT_W    = 16,
  parameter int WAIT_TIMEOUT = 32
) (
  input  logic                 REF_CLK,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic                 WrEn,
  output logic                 RdEn,
  output logic [ADDR_W-1:0]    ADDRESS,
  output logic [DATA_W-1:0]    WrData,
  input  logic [DATA_W-1:0]    RdData,
  input  logic                 RdData_Valid,
  output logic [3:0]           ALU_FUN,
  output logic                 ALU_EN,
  output logic                 CLK_GATE_EN,
  input  logic [ALU_OUT_W-1:0] ALU_OUT,
  input  logic                 ALU_OUT_VLD,
  output logic [DATA_W-1:0]    TX_P_DATA,
  output logic                 TX_D_VLD,
  input  logic                 FIFO_FULL,
  output logic                 ERR
);

  localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);
  localparam logic [DATA_W-1:0] CMD_WR   = DATA_W'(8'hAA);
  localparam logic [DATA_W-1:0] CMD_RD   = DATA_W'(8'hBB);
  localparam logic [DATA_W-1:0] CMD_ALU  = DATA_W'(8'hCC);
  localparam logic [DATA_W-1:0] CMD_NOP  = DATA_W'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND,
    ALU_A, ALU_B, ALU_FUN_S, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ALU_OUT_W-1:0]  res_q, res_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]     address_q, address_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  alu_en_q, alu_en_d;
  logic                  gate_q, gate_d;
  logic [DATA_W-1:0]     tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  err_q, err_d;

  always_ff @(posedge REF_CLK) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      res_q     <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      address_q <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
      alu_en_q  <= 1'b0;
      gate_q    <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      res_q     <= res_d;
      tmo_q     <= tmo_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      address_q <= address_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q  <= alu_en_d;
      gate_q    <= gate_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    res_d     = res_q;
    tmo_d     = tmo_q;
    address_d = address_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    gate_d    = gate_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == CMD_WR)       state_d = WR_ADDR;
          else if (RX_P_DATA == CMD_RD)  state_d = RD_ADDR;
          else if (RX_P_DATA == CMD_ALU) state_d = ALU_A;
          else if (RX_P_DATA == CMD_NOP) state_d = ALU_FUN_S;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_W-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = addr_q;
          wr_data_d = RX_P_DATA;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rd_en_d   = 1'b1;
          address_d = RX_P_DATA[ADDR_W-1:0];
          tmo_d     = '0;
          state_d   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // A valid arriving on the timeout cycle still wins.
        if (RdData_Valid) begin
          res_d   = ALU_OUT_W'(RdData);
          state_d = RD_SEND;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RD_SEND: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[DATA_W-1:0];
          state_d   = IDLE;
        end
      end
      ALU_A: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = '0;
          wr_data_d = RX_P_DATA;
          state_d   = ALU_B;
        end
      end
      ALU_B: begin
        if (RX_D_VLD) begin
          wr_en_d   = 1'b1;
          address_d = ADDR_W'(1);
          wr_data_d = RX_P_DATA;
          state_d   = ALU_FUN_S;
        end
      end
      ALU_FUN_S: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          gate_d    = 1'b1;
          tmo_d     = '0;
          state_d   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          res_d   = ALU_OUT;
          gate_d  = 1'b0;
          state_d = TX_LO;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          gate_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      TX_LO: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[DATA_W-1:0];
          state_d   = TX_HI;
        end
      end
      TX_HI: begin
        if (!FIFO_FULL) begin
          tx_vld_d  = 1'b1;
          tx_data_d = res_q[ALU_OUT_W-1:DATA_W];
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign WrEn        = wr_en_q;
  assign RdEn        = rd_en_q;
  assign ADDRESS     = address_q;
  assign WrData      = wr_data_q;
  assign ALU_FUN     = alu_fun_q;
  assign ALU_EN      = alu_en_q;
  assign CLK_GATE_EN = gate_q;
  assign TX_P_DATA   = tx_data_q;
  assign TX_D_VLD    = tx_vld_q;
  assign ERR         = err_q;

endmodule
